seq_detector_prog: RTL and testbench

//  Runtime-programmable serial bit-pattern detector. Successor to the fixed 4-bit Moore detector.

---
 rtl/seq_det_pkg.sv | 32 +++
 rtl/seq_det_match_cnt.sv | 24 ++
 rtl/seq_detector_prog.sv | 98 +++++++++
 tb/tb_seq_detector_prog.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types, reset constants and helpers for the programmable sequence detector.
// Counter build option: SEQDET_COUNT_EN (see seq_detector_prog).
package seq_det_pkg;

    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_e;

    localparam int unsigned SEQ_DEF_MAX_LEN = 16;
    localparam int unsigned SEQ_DEF_LEN     = 4;
    localparam logic [15:0] SEQ_DEF_PAT     = 16'h000B;
    localparam ovl_e        SEQ_DEF_OVL     = OVL_OFF;
    localparam int unsigned SEQ_DEF_CNT_W   = 16;

    // Widest pattern the lenmask helper can describe; callers cast down to MAX_LEN.
    localparam int unsigned LENMASK_W = 64;

    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic logic [LENMASK_W-1:0] lenmask(input int unsigned len);
        logic [LENMASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < LENMASK_W; i++) begin
            if (i < len) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter; clear takes priority over increment.
module seq_det_match_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with don't-care mask and overlap mode.
// Define SEQDET_COUNT_EN to build the saturating match counter.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int unsigned        MAX_LEN = SEQ_DEF_MAX_LEN,
    parameter int unsigned        DEF_LEN = SEQ_DEF_LEN,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(SEQ_DEF_PAT),
    parameter logic               DEF_OVL = SEQ_DEF_OVL,
    parameter int unsigned        CNT_W   = SEQ_DEF_CNT_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_vld,
    input  logic                             in_bit,
    input  logic                             cfg_we,
    input  logic [$clog2(MAX_LEN+1)-1:0]     cfg_len,
    input  logic [MAX_LEN-1:0]               cfg_pat,
    input  logic [MAX_LEN-1:0]               cfg_mask,
    input  logic                             cfg_ovl,
    output logic                             match,
    output logic [CNT_W-1:0]                 match_cnt,
    input  logic                             cnt_clr
);

    localparam int unsigned        LEN_W  = len_width(MAX_LEN);
    localparam logic [MAX_LEN-1:0] DEF_LM = MAX_LEN'(lenmask(DEF_LEN));

    logic [LEN_W-1:0]   len_q, fill_q, fill_n, cfg_len_c;
    logic [MAX_LEN-1:0] pat_q, mask_q, hist_q, hist_n, cfg_lm;
    ovl_e               ovl_q;
    logic               match_q, hit;

    always_comb begin
        cfg_len_c = cfg_len;
        if (cfg_len == '0) begin
            cfg_len_c = LEN_W'(1);
        end else if (cfg_len > LEN_W'(MAX_LEN)) begin
            cfg_len_c = LEN_W'(MAX_LEN);
        end
    end

    // Pattern and mask are stored pre-trimmed to len, so the compare needs no lenmask.
    assign cfg_lm = MAX_LEN'(lenmask(32'(cfg_len_c)));

    assign hist_n = {hist_q[MAX_LEN-2:0], in_bit};
    assign fill_n = (fill_q == len_q) ? len_q : fill_q + LEN_W'(1);
    assign hit    = in_vld && !cfg_we && (fill_n == len_q) &&
                    (((hist_n ^ pat_q) & mask_q) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= LEN_W'(DEF_LEN);
            pat_q   <= DEF_PAT & DEF_LM;
            mask_q  <= DEF_LM;
            ovl_q   <= ovl_e'(DEF_OVL);
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else if (cfg_we) begin
            len_q   <= cfg_len_c;
            pat_q   <= cfg_pat & cfg_lm;
            mask_q  <= cfg_mask & cfg_lm;
            ovl_q   <= ovl_e'(cfg_ovl);
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else if (in_vld) begin
            hist_q  <= hist_n;
            match_q <= hit;
            fill_q  <= (hit && (ovl_q == OVL_OFF)) ? '0 : fill_n;
        end
    end

    assign match = match_q;

    // The oldest history bit is shifted out without ever being compared.
    logic unused_hist_msb;
    assign unused_hist_msb = hist_q[MAX_LEN-1];

`ifdef SEQDET_COUNT_EN
    seq_det_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (hit),
        .cnt (match_cnt)
    );
`else
    assign match_cnt = '0;

    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog; expectations follow the SEQDET_COUNT_EN setting.
module tb_seq_detector_prog;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned CNT_W   = 2;
`ifdef SEQDET_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst, in_vld, in_bit, cfg_we, cfg_ovl, cnt_clr;
    logic [LEN_W-1:0]   cfg_len;
    logic [MAX_LEN-1:0] cfg_pat, cfg_mask;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    seq_detector_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_bit    (in_bit),
        .cfg_we    (cfg_we),
        .cfg_len   (cfg_len),
        .cfg_pat   (cfg_pat),
        .cfg_mask  (cfg_mask),
        .cfg_ovl   (cfg_ovl),
        .match     (match),
        .match_cnt (match_cnt),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted bit per char of bits; exp gives the match value after each edge.
    task automatic send_seq(input string tag, input string bits, input string exp);
        for (int i = 0; i < bits.len(); i++) begin
            in_vld = 1'b1;
            in_bit = (bits[i] == 8'h31);
            tick();
            in_vld = 1'b0;
            chk($sformatf("%s[%0d]", tag, i), 32'(match), 32'(exp[i] == 8'h31));
        end
    endtask

    task automatic idle(input string tag, input int n, input logic exp);
        in_bit = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s[%0d]", tag, i), 32'(match), 32'(exp));
        end
    endtask

    task automatic do_cfg(input logic [LEN_W-1:0] l, input logic [MAX_LEN-1:0] p,
                          input logic [MAX_LEN-1:0] m, input logic o);
        cfg_len  = l;
        cfg_pat  = p;
        cfg_mask = m;
        cfg_ovl  = o;
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
        chk("cfg_clears_match", 32'(match), 32'(0));
    endtask

    task automatic do_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_bit = 1'b0; cfg_we = 1'b0; cfg_ovl = 1'b0;
        cnt_clr = 1'b0; cfg_len = '0; cfg_pat = '0; cfg_mask = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_match", 32'(match), 32'(0));
        chk("reset_cnt", 32'(match_cnt), 32'(0));

        // Defaults: len 4, 1011, non-overlapping
        send_seq("def_1011011", "1011011", "0001000");
        do_rst();
        send_seq("def_two", "10111011", "00010001");

        // Overlap vs non-overlap on 10101
        do_cfg(LEN_W'(3), 16'h0005, 16'hFFFF, 1'b1);
        send_seq("ovl_on", "10101", "00101");
        do_cfg(LEN_W'(3), 16'h0005, 16'hFFFF, 1'b0);
        send_seq("ovl_off", "10101", "00100");

        // Don't-care on bit 2
        do_cfg(LEN_W'(4), 16'h0009, 16'h000B, 1'b0);
        send_seq("mask_1001", "1001", "0001");
        send_seq("mask_1101", "1101", "0001");
        send_seq("mask_1000", "1000", "0000");

        // in_vld gaps with in_bit held at 1 while idle
        do_rst();
        send_seq("gap_b0", "1", "0");
        idle("gap_i0", 1, 1'b0);
        send_seq("gap_b1", "0", "0");
        idle("gap_i1", 2, 1'b0);
        send_seq("gap_b2", "1", "0");
        idle("gap_i2", 1, 1'b0);
        send_seq("gap_b3", "1", "1");
        idle("gap_hold", 3, 1'b1);
        send_seq("gap_after", "0", "0");

        // Config write collides with a valid bit: bit dropped, history cleared
        do_rst();
        send_seq("cfgmid_pre", "101", "000");
        in_vld = 1'b1;
        in_bit = 1'b1;
        do_cfg(LEN_W'(4), 16'h000B, 16'hFFFF, 1'b0);
        in_vld = 1'b0;
        send_seq("cfgmid_post", "1011", "0001");
        do_cfg(LEN_W'(4), 16'h000B, 16'hFFFF, 1'b0);

        // Reset mid-pattern
        send_seq("rstmid_pre", "101", "000");
        do_rst();
        chk("rstmid_match", 32'(match), 32'(0));
        send_seq("rstmid_post", "1011", "0001");

        // Length clamping and ignored upper pattern bits
        do_cfg(LEN_W'(0), 16'h0001, 16'hFFFF, 1'b0);
        send_seq("len0", "1101", "1101");
        do_cfg(LEN_W'(31), 16'hFFFF, 16'hFFFF, 1'b0);
        send_seq("len_clamp", "1111111111111111", "0000000000000001");
        do_cfg(LEN_W'(2), 16'hFFF1, 16'h0003, 1'b0);
        send_seq("len2_hi_ignored", "0101", "0101");

        // Match counter (CNT_W=2)
        do_cfg(LEN_W'(1), 16'h0001, 16'hFFFF, 1'b0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_clr_idle", 32'(match_cnt), 32'(0));
        for (int i = 0; i < 5; i++) begin
            send_seq($sformatf("cnt_hit%0d", i), "1", "1");
            chk($sformatf("cnt_val%0d", i), 32'(match_cnt),
                CNT_EN ? ((i + 1 > 3) ? 32'd3 : 32'(i + 1)) : 32'd0);
        end
        cnt_clr = 1'b1;
        send_seq("cnt_clr_hit", "1", "1");
        cnt_clr = 1'b0;
        chk("cnt_clr_on_hit", 32'(match_cnt), 32'(0));
        send_seq("cnt_after_clr", "1", "1");
        chk("cnt_after_clr_val", 32'(match_cnt), CNT_EN ? 32'd1 : 32'd0);
        do_cfg(LEN_W'(4), 16'h000B, 16'hFFFF, 1'b0);
        chk("cnt_kept_by_cfg", 32'(match_cnt), CNT_EN ? 32'd1 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
